boot_exit_sequencer: RTL



---
 rtl/boot_exit_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/boot_exit_sequencer.sv
// Orderly exit from the SPI bootloader: wait for quiet buses, detach from USB,
// then pulse PROGRAMN low to reconfigure from flash. Terminal HOLD until reset.
module boot_exit_sequencer #(
    parameter int QUIET_CYCLES  = 48,
    parameter int DETACH_CYCLES = 480000,
    parameter int PROGN_CYCLES  = 4800,
    parameter int CNT_W         = 20
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       boot_req,
    input  logic       spi_cs,
    input  logic       usb_tx_en,
    output logic       usb_pu_en,
    output logic       usb_force_se0,
    output logic       programn,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_QUIET = 3'd1,
        DETACH     = 3'd2,
        PROG       = 3'd3,
        HOLD       = 3'd4
    } state_e;

    localparam longint CNT_SPAN = longint'(64'sd1) <<< CNT_W;

    // Each duration minus one has to fit in the shared counter.
    if ((QUIET_CYCLES < 32'sd1) || (longint'(QUIET_CYCLES) > CNT_SPAN)) begin : g_bad_quiet
        $error("QUIET_CYCLES out of range for CNT_W");
    end
    if ((DETACH_CYCLES < 32'sd1) || (longint'(DETACH_CYCLES) > CNT_SPAN)) begin : g_bad_detach
        $error("DETACH_CYCLES out of range for CNT_W");
    end
    if ((PROGN_CYCLES < 32'sd1) || (longint'(PROGN_CYCLES) > CNT_SPAN)) begin : g_bad_progn
        $error("PROGN_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] QUIET_LOAD  = CNT_W'(QUIET_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] DETACH_LOAD = CNT_W'(DETACH_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] PROGN_LOAD  = CNT_W'(PROGN_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(32'sd0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'sd1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             usb_pu_en_q, usb_pu_en_d;
    logic             usb_force_se0_q, usb_force_se0_d;
    logic             programn_q, programn_d;
    logic             busy_q, busy_d;
    logic             bus_active_s;

    assign bus_active_s = (~spi_cs) | usb_tx_en;

    // Next-state and counter logic; the counter only reloads or steps down toward zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (boot_req) begin
                    state_d = WAIT_QUIET;
                    cnt_d   = QUIET_LOAD;
                end else begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            WAIT_QUIET: begin
                if (!boot_req) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (bus_active_s) begin
                    state_d = WAIT_QUIET;
                    cnt_d   = QUIET_LOAD;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = DETACH;
                    cnt_d   = DETACH_LOAD;
                end else begin
                    state_d = WAIT_QUIET;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            DETACH: begin
                // Committed: request and bus activity are no longer looked at.
                if (cnt_q == CNT_ZERO) begin
                    state_d = PROG;
                    cnt_d   = PROGN_LOAD;
                end else begin
                    state_d = DETACH;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            PROG: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = HOLD;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = PROG;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                state_d = HOLD;
                cnt_d   = CNT_ZERO;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Outputs decoded from the next state so they register on the transition edge.
    always_comb begin
        usb_pu_en_d     = 1'b1;
        usb_force_se0_d = 1'b0;
        programn_d      = 1'b1;
        busy_d          = 1'b0;
        case (state_d)
            IDLE: begin
                usb_pu_en_d     = 1'b1;
                usb_force_se0_d = 1'b0;
                programn_d      = 1'b1;
                busy_d          = 1'b0;
            end
            WAIT_QUIET: begin
                usb_pu_en_d     = 1'b1;
                usb_force_se0_d = 1'b0;
                programn_d      = 1'b1;
                busy_d          = 1'b1;
            end
            DETACH: begin
                usb_pu_en_d     = 1'b0;
                usb_force_se0_d = 1'b1;
                programn_d      = 1'b1;
                busy_d          = 1'b1;
            end
            PROG: begin
                usb_pu_en_d     = 1'b0;
                usb_force_se0_d = 1'b1;
                programn_d      = 1'b0;
                busy_d          = 1'b1;
            end
            HOLD: begin
                usb_pu_en_d     = 1'b0;
                usb_force_se0_d = 1'b0;
                programn_d      = 1'b1;
                busy_d          = 1'b1;
            end
            default: begin
                usb_pu_en_d     = 1'b1;
                usb_force_se0_d = 1'b0;
                programn_d      = 1'b1;
                busy_d          = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= CNT_ZERO;
            usb_pu_en_q     <= 1'b1;
            usb_force_se0_q <= 1'b0;
            programn_q      <= 1'b1;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            usb_pu_en_q     <= usb_pu_en_d;
            usb_force_se0_q <= usb_force_se0_d;
            programn_q      <= programn_d;
            busy_q          <= busy_d;
        end
    end

    assign usb_pu_en     = usb_pu_en_q;
    assign usb_force_se0 = usb_force_se0_q;
    assign programn      = programn_q;
    assign busy          = busy_q;
    assign state         = state_q;

endmodule
